// File: rtl/adc_serial_capture_if.sv
// Pin and readout bundle for adc_serial_capture: ADC-side strobes/data, control pulses, read port.
// The capture engine uses the slave modport; the readout/host side uses master.
interface adc_serial_capture_if #(
    parameter int unsigned NCH        = 2,
    parameter int unsigned STORE_BITS = 16,
    parameter int unsigned AW         = 14
);
    localparam int unsigned CW = (NCH > 1) ? $clog2(NCH) : 1;

    logic                  START;
    logic                  STOP;
    logic                  PCLR;
    logic                  ADCLK;
    logic                  SCLK;
    logic [NCH-1:0]        SDOUT;
    logic [NCH-1:0]        BUSY;
    logic [CW-1:0]         RD_CH;
    logic [AW-1:0]         RD_ADDR;
    logic [STORE_BITS-1:0] RD_DATA;
    logic [AW-1:0]         WADRS;
    logic                  RUN;
    logic                  FULL;
    logic                  ERR;
    logic                  SAMPLE_STB;

    modport slave (
        input  START, STOP, PCLR, SDOUT, BUSY, RD_CH, RD_ADDR,
        output ADCLK, SCLK, RD_DATA, WADRS, RUN, FULL, ERR, SAMPLE_STB
    );

    modport master (
        output START, STOP, PCLR, SDOUT, BUSY, RD_CH, RD_ADDR,
        input  ADCLK, SCLK, RD_DATA, WADRS, RUN, FULL, ERR, SAMPLE_STB
    );
endinterface

// File: rtl/adc_serial_capture.sv
// Multi-channel capture engine for serial-slave SAR ADCs: periodic conversion start, parallel
// shift-in on a shared SCLK, and per-channel sample buffers drained through a 1-cycle read port.
module adc_serial_capture #(
    parameter int unsigned NCH        = 2,
    parameter int unsigned ADC_BITS   = 18,
    parameter int unsigned STORE_BITS = 16,
    parameter int unsigned AW         = 14,
    parameter int unsigned PERIOD     = 100,
    parameter int unsigned BUSY_TMO   = 64,
    parameter int unsigned WRAP       = 0
) (
    input  logic                CLK,
    input  logic                RSTN,
    adc_serial_capture_if.slave bus
);
    localparam int unsigned DEPTH = 2 ** AW;
    localparam int unsigned CW    = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int unsigned PW    = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam int unsigned TW    = $clog2(BUSY_TMO + 1);
    localparam int unsigned SW    = $clog2(2 * ADC_BITS);

    typedef enum logic [2:0] {
        StIdle, StConv, StWaitb, StShift, StStore, StGap
    } state_e;

    state_e                             state_q, state_d;
    logic [PW-1:0]                      per_q, per_d;
    logic [TW-1:0]                      wcnt_q, wcnt_d;
    logic [SW-1:0]                      scnt_q, scnt_d;
    logic                               sclk_q, sclk_d;
    logic                               adclk_q;
    logic [AW-1:0]                      wadrs_q, wadrs_d;
    logic                               full_q, full_d;
    logic                               err_q, err_d;
    logic                               stop_q, stop_d;
    logic                               stb_q;
    logic [NCH-1:0][ADC_BITS-1:0]       shreg_q, shreg_d;
    logic                               we;
    logic                               rd_ok_q;
    logic [CW-1:0]                      rd_ch_q;
    logic [NCH*STORE_BITS-1:0]          rd_all;
    logic [STORE_BITS-1:0]              rd_data;

    always_comb begin
        state_d = state_q;
        // Saturates so a stretched sequence launches the next conversion straight from GAP.
        per_d   = (per_q == PW'(PERIOD - 1)) ? per_q : per_q + 1'b1;
        wcnt_d  = '0;
        scnt_d  = '0;
        sclk_d  = 1'b0;
        wadrs_d = wadrs_q;
        full_d  = full_q;
        err_d   = err_q;
        stop_d  = stop_q;
        shreg_d = shreg_q;
        we      = 1'b0;

        if (bus.STOP && state_q != StIdle) stop_d = 1'b1;

        unique case (state_q)
            StIdle: begin
                if (bus.START && !full_q) state_d = StConv;
            end
            StConv: state_d = StWaitb;
            StWaitb: begin
                wcnt_d = wcnt_q + 1'b1;
                if (wcnt_q != '0 && !(|bus.BUSY)) begin
                    state_d = StShift;
                end else if (wcnt_q == TW'(BUSY_TMO - 1)) begin
                    err_d   = 1'b1;
                    state_d = StShift;
                end
            end
            StShift: begin
                sclk_d = ~sclk_q;
                scnt_d = scnt_q + 1'b1;
                // Capture on the cycle that drives SCLK high.
                if (!sclk_q) begin
                    for (int c = 0; c < NCH; c++) begin
                        shreg_d[c] = {shreg_q[c][ADC_BITS-2:0], bus.SDOUT[c]};
                    end
                end
                if (scnt_q == SW'(2 * ADC_BITS - 1)) state_d = StStore;
            end
            StStore: begin
                we      = 1'b1;
                wadrs_d = wadrs_q + 1'b1;
                shreg_d = '0;
                stop_d  = 1'b0;
                if ((&wadrs_q) && WRAP == 0) begin
                    full_d  = 1'b1;
                    state_d = StIdle;
                end else if (stop_q || bus.STOP) begin
                    state_d = StIdle;
                end else begin
                    state_d = StGap;
                end
            end
            StGap: begin
                if (per_q == PW'(PERIOD - 1)) state_d = StConv;
            end
            default: state_d = StIdle;
        endcase

        if (state_d == StConv) per_d = '0;

        if (bus.PCLR) begin
            state_d = StIdle;
            wadrs_d = '0;
            full_d  = 1'b0;
            err_d   = 1'b0;
            stop_d  = 1'b0;
            sclk_d  = 1'b0;
            shreg_d = '0;
            we      = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            state_q <= StIdle;
            per_q   <= '0;
            wcnt_q  <= '0;
            scnt_q  <= '0;
            sclk_q  <= 1'b0;
            adclk_q <= 1'b1;
            wadrs_q <= '0;
            full_q  <= 1'b0;
            err_q   <= 1'b0;
            stop_q  <= 1'b0;
            stb_q   <= 1'b0;
            shreg_q <= '0;
            rd_ok_q <= 1'b0;
            rd_ch_q <= '0;
        end else begin
            state_q <= state_d;
            per_q   <= per_d;
            wcnt_q  <= wcnt_d;
            scnt_q  <= scnt_d;
            sclk_q  <= sclk_d;
            adclk_q <= (state_d != StConv);
            wadrs_q <= wadrs_d;
            full_q  <= full_d;
            err_q   <= err_d;
            stop_q  <= stop_d;
            stb_q   <= we;
            shreg_q <= shreg_d;
            rd_ok_q <= ({1'b0, bus.RD_CH} < (CW + 1)'(NCH));
            rd_ch_q <= bus.RD_CH;
        end
    end

    // Per-channel buffer; a same-cycle read of the write address returns the old word.
    for (genvar c = 0; c < NCH; c++) begin : g_ch
        logic [STORE_BITS-1:0] mem [DEPTH];
        logic [STORE_BITS-1:0] rd_q;

        always_ff @(posedge CLK) begin
            if (we) mem[wadrs_q] <= shreg_q[c][ADC_BITS-1 -: STORE_BITS];
            rd_q <= mem[bus.RD_ADDR];
        end

        assign rd_all[c*STORE_BITS +: STORE_BITS] = rd_q;
    end

    always_comb begin
        rd_data = '0;
        for (int c = 0; c < NCH; c++) begin
            if (rd_ok_q && rd_ch_q == CW'(c)) rd_data = rd_all[c*STORE_BITS +: STORE_BITS];
        end
    end

    assign bus.ADCLK      = adclk_q;
    assign bus.SCLK       = sclk_q;
    assign bus.WADRS      = wadrs_q;
    assign bus.RUN        = (state_q != StIdle);
    assign bus.FULL       = full_q;
    assign bus.ERR        = err_q;
    assign bus.SAMPLE_STB = stb_q;
    assign bus.RD_DATA    = rd_data;
endmodule

// File: tb/tb_adc_serial_capture.sv
// Directed bench for adc_serial_capture: a stop-on-full and a wrapping instance, each driven by
// a small serial-ADC model that presents a fixed 18-bit word MSB first.
module tb_adc_serial_capture;
    localparam int unsigned NCH        = 2;
    localparam int unsigned ADC_BITS   = 18;
    localparam int unsigned STORE_BITS = 16;
    localparam int unsigned AW         = 4;
    localparam int unsigned PERIOD     = 64;
    localparam int unsigned BUSY_TMO   = 16;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    logic                  start   [2];
    logic                  stop    [2];
    logic                  pclr    [2];
    logic                  rd_ch   [2];
    logic [AW-1:0]         rd_addr [2];
    logic                  adclk   [2];
    logic                  sclk    [2];
    logic                  run     [2];
    logic                  full    [2];
    logic                  err     [2];
    logic                  stb     [2];
    logic [AW-1:0]         wadrs   [2];
    logic [STORE_BITS-1:0] rd_data [2];
    logic [ADC_BITS-1:0]   word    [2];
    logic                  busy_force;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    for (genvar g = 0; g < 2; g++) begin : g_inst
        adc_serial_capture_if #(.NCH(NCH), .STORE_BITS(STORE_BITS), .AW(AW)) bus ();

        adc_serial_capture #(
            .NCH(NCH), .ADC_BITS(ADC_BITS), .STORE_BITS(STORE_BITS), .AW(AW),
            .PERIOD(PERIOD), .BUSY_TMO(BUSY_TMO), .WRAP(g)
        ) dut (
            .CLK (clk),
            .RSTN(rstn),
            .bus (bus)
        );

        int rises = 0;
        int bcnt = 0;
        logic sclk_prev = 1'b0;
        logic [NCH-1:0] sd;

        // ADC model: BUSY for 3 cycles after ADCLK low; next bit presented after each SCLK rise.
        always @(negedge clk) begin
            if (!bus.ADCLK) begin
                rises <= 0;
                bcnt  <= 3;
            end else begin
                if (bus.SCLK && !sclk_prev) rises <= rises + 1;
                if (bcnt > 0) bcnt <= bcnt - 1;
            end
            sclk_prev <= bus.SCLK;
        end

        always_comb begin
            sd = '0;
            for (int c = 0; c < NCH; c++) begin
                if (rises < ADC_BITS) sd[c] = word[c][ADC_BITS-1-rises];
            end
        end

        assign bus.SDOUT   = sd;
        assign bus.BUSY    = {NCH{(bcnt != 0) || busy_force}};
        assign bus.START   = start[g];
        assign bus.STOP    = stop[g];
        assign bus.PCLR    = pclr[g];
        assign bus.RD_CH   = rd_ch[g];
        assign bus.RD_ADDR = rd_addr[g];
        assign adclk[g]    = bus.ADCLK;
        assign sclk[g]     = bus.SCLK;
        assign run[g]      = bus.RUN;
        assign full[g]     = bus.FULL;
        assign err[g]      = bus.ERR;
        assign stb[g]      = bus.SAMPLE_STB;
        assign wadrs[g]    = bus.WADRS;
        assign rd_data[g]  = bus.RD_DATA;
    end

    // Activity monitor on instance 0.
    int stb_cnt = 0, adclk_low_cnt = 0, rise_cnt = 0, lat = 0, conv_cyc = 0;
    logic rise_seen = 1'b0, adclk_prev = 1'b1, sclk_prev0 = 1'b0;
    int fall_t[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!adclk[0]) begin
            adclk_low_cnt <= adclk_low_cnt + 1;
            if (adclk_prev) begin
                fall_t.push_back(cyc);
                conv_cyc  <= cyc;
                rise_seen <= 1'b0;
            end
        end
        if (sclk[0] && !sclk_prev0) begin
            rise_cnt <= rise_cnt + 1;
            if (!rise_seen) begin
                lat       <= cyc - conv_cyc;
                rise_seen <= 1'b1;
            end
        end
        if (stb[0]) stb_cnt <= stb_cnt + 1;
        adclk_prev <= adclk[0];
        sclk_prev0 <= sclk[0];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_stb(input int g, input string tag);
        bit ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            tick(1);
            if (stb[g]) ok = 1'b1;
        end
        check(tag, ok, 1);
    endtask

    task automatic wait_sclk(input int g, input string tag);
        bit ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            tick(1);
            if (sclk[g]) ok = 1'b1;
        end
        check(tag, ok, 1);
    endtask

    task automatic pulse(input int g, input bit s, input bit p, input bit c);
        start[g] = s;
        stop[g]  = p;
        pclr[g]  = c;
        tick(1);
        start[g] = 1'b0;
        stop[g]  = 1'b0;
        pclr[g]  = 1'b0;
    endtask

    task automatic rd_check(input int g, input int ch, input int addr, input logic [15:0] exp,
                            input string tag);
        rd_ch[g]   = ch[0];
        rd_addr[g] = addr[AW-1:0];
        tick(1);
        check(tag, rd_data[g], exp);
    endtask

    int fb, sb, ab, rb;

    initial begin
        rstn       = 1'b0;
        busy_force = 1'b0;
        for (int g = 0; g < 2; g++) begin
            start[g]   = 1'b0;
            stop[g]    = 1'b0;
            pclr[g]    = 1'b0;
            rd_ch[g]   = 1'b0;
            rd_addr[g] = '0;
            word[g]    = '0;
        end
        tick(2);
        check("rst_run", run[0], 0);
        check("rst_full", full[0], 0);
        check("rst_err", err[0], 0);
        check("rst_wadrs", wadrs[0], 0);
        check("rst_adclk", adclk[0], 1);
        check("rst_sclk", sclk[0], 0);
        check("rst_stb", stb[0], 0);
        check("rst_rdata", rd_data[0], 0);
        rstn = 1'b1;
        tick(1);

        // Ten back-to-back samples, stop requested during the tenth.
        word[0] = 18'h2AAAB;
        word[1] = 18'h3FFFF;
        fb = fall_t.size();
        sb = stb_cnt;
        ab = adclk_low_cnt;
        rb = rise_cnt;
        pulse(0, 1, 0, 0);
        check("t1_run", run[0], 1);
        check("t1_adclk_low", adclk[0], 0);
        repeat (9) wait_stb(0, "t2_stb_wait");
        pulse(0, 0, 1, 0);
        wait_stb(0, "t2_stb10_wait");
        check("t2_run_off", run[0], 0);
        tick(2);
        check("t2_wadrs", wadrs[0], 10);
        check("t2_stb_cnt", stb_cnt - sb, 10);
        check("t1_adclk_cycles", adclk_low_cnt - ab, 10);
        check("t1_sclk_rises", rise_cnt - rb, 180);
        check("t2_conv_cnt", fall_t.size() - fb, 10);
        check("t1_busy_lat", lat, 5);
        for (int i = fb + 1; i < fb + 10 && i < fall_t.size(); i++) begin
            check("t2_period", fall_t[i] - fall_t[i-1], PERIOD);
        end
        rd_check(0, 0, 0, 16'hAAAA, "t1_mem0_0");
        rd_check(0, 1, 0, 16'hFFFF, "t1_mem1_0");
        rd_check(0, 0, 9, 16'hAAAA, "t2_mem0_9");
        rd_check(0, 1, 9, 16'hFFFF, "t2_mem1_9");

        // STOP mid-shift still stores the sample.
        word[0] = 18'h12345;
        word[1] = 18'h00003;
        pulse(0, 1, 0, 0);
        wait_sclk(0, "t4_sclk_wait");
        tick(5);
        pulse(0, 0, 1, 0);
        wait_stb(0, "t4_stb_wait");
        check("t4_run_off", run[0], 0);
        check("t4_wadrs", wadrs[0], 11);
        rd_check(0, 0, 10, 16'h48D1, "t4_mem0_10");
        rd_check(0, 1, 10, 16'h0000, "t4_mem1_10");

        // PCLR mid-shift aborts; memory untouched; PCLR beats START.
        pulse(0, 1, 0, 0);
        wait_sclk(0, "t6_sclk_wait");
        tick(3);
        pulse(0, 0, 0, 1);
        check("t6_pclr_adclk", adclk[0], 1);
        check("t6_pclr_sclk", sclk[0], 0);
        check("t6_pclr_wadrs", wadrs[0], 0);
        check("t6_pclr_run", run[0], 0);
        rd_check(0, 0, 10, 16'h48D1, "t6_mem_kept_10");
        rd_check(0, 0, 0, 16'hAAAA, "t6_mem_kept_0");
        pulse(0, 1, 0, 1);
        check("t6_pclr_start_run", run[0], 0);
        tick(3);
        check("t6_pclr_start_idle", run[0], 0);

        // BUSY stuck high: timeout sets ERR, sample still stored.
        busy_force = 1'b1;
        word[0] = 18'h3C3C3;
        word[1] = 18'h00000;
        pulse(0, 1, 0, 0);
        pulse(0, 0, 1, 0);
        tick(10);
        check("t5_err_early", err[0], 0);
        wait_stb(0, "t5_stb_wait");
        check("t5_err", err[0], 1);
        check("t5_lat", lat, BUSY_TMO + 2);
        check("t5_wadrs", wadrs[0], 1);
        rd_check(0, 0, 0, 16'hF0F0, "t5_mem0_0");
        rd_check(0, 1, 0, 16'h0000, "t5_mem1_0");
        busy_force = 1'b0;
        pulse(0, 1, 0, 0);
        pulse(0, 0, 1, 0);
        wait_stb(0, "t5b_stb_wait");
        check("t5_err_sticky", err[0], 1);
        check("t5b_wadrs", wadrs[0], 2);

        // RSTN mid-shift.
        pulse(0, 1, 0, 0);
        wait_sclk(0, "t6r_sclk_wait");
        tick(3);
        rstn = 1'b0;
        tick(1);
        check("t6r_adclk", adclk[0], 1);
        check("t6r_sclk", sclk[0], 0);
        check("t6r_wadrs", wadrs[0], 0);
        check("t6r_run", run[0], 0);
        check("t6r_err", err[0], 0);
        rstn = 1'b1;
        rd_check(0, 0, 1, 16'hF0F0, "t6r_mem_kept");

        // Fill: instance 0 stops on full, instance 1 wraps.
        word[0] = 18'h0FFFC;
        word[1] = 18'h30000;
        start[0] = 1'b1;
        start[1] = 1'b1;
        tick(1);
        start[0] = 1'b0;
        start[1] = 1'b0;
        repeat (16) wait_stb(1, "t3_stb_wait");
        check("t3_full0", full[0], 1);
        check("t3_run0", run[0], 0);
        check("t3_wadrs0", wadrs[0], 0);
        check("t3_full1", full[1], 0);
        check("t3_run1", run[1], 1);
        check("t3_wadrs1", wadrs[1], 0);
        word[0] = 18'h00004;
        word[1] = 18'h3FFFC;
        start[0] = 1'b1;
        stop[1]  = 1'b1;
        tick(1);
        start[0] = 1'b0;
        stop[1]  = 1'b0;
        wait_stb(1, "t3_stb17_wait");
        check("t3_start_ignored", run[0], 0);
        check("t3_full0_held", full[0], 1);
        check("t3_wrap_wadrs", wadrs[1], 1);
        check("t3_wrap_full", full[1], 0);
        rd_check(1, 0, 0, 16'h0001, "t3_wrap_mem0_0");
        rd_check(1, 1, 0, 16'hFFFF, "t3_wrap_mem1_0");
        rd_check(1, 0, 1, 16'h3FFF, "t3_wrap_mem0_1");
        rd_check(1, 1, 15, 16'hC000, "t3_wrap_mem1_15");
        rd_check(0, 0, 15, 16'h3FFF, "t3_full_mem0_15");
        pulse(0, 0, 0, 1);
        check("t3_pclr_full", full[0], 0);
        pulse(0, 1, 0, 0);
        check("t3_restart_run", run[0], 1);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end
endmodule
